// File: rtl/aes_pkg.sv
// Shared types and sizes for the AES input loader: FSM encoding and word geometry.
package aes_pkg;
  localparam int WORD_W    = 32;
  localparam int KEY_WORDS = 8;
  localparam int BLK_WORDS = 4;

  typedef enum logic {
    ST_FILL = 1'b0,
    ST_RUN  = 1'b1
  } state_e;
endpackage

// File: rtl/aes_word_shifter.sv
// Word-serial shift register: each accepted word enters at the LSB end; full_o pulses
// combinationally on the handshake that completes NWORDS words, and the count wraps to 0.
module aes_word_shifter
  import aes_pkg::*;
#(
  parameter int NWORDS = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_n,
  input  logic                       shift_i,
  input  logic [WORD_W-1:0]          word_i,
  output logic [NWORDS*WORD_W-1:0]   data_o,
  output logic [$clog2(NWORDS)-1:0]  cnt_o,
  output logic                       full_o
);
  localparam int CW = $clog2(NWORDS);
  localparam int DW = NWORDS * WORD_W;

  logic [DW-1:0] data_q, data_d;
  logic [CW-1:0] cnt_q, cnt_d;

  assign full_o = shift_i && (cnt_q == CW'(NWORDS - 1));

  always_comb begin
    data_d = data_q;
    cnt_d  = cnt_q;
    if (shift_i) begin
      data_d = {data_q[DW-WORD_W-1:0], word_i};
      cnt_d  = full_o ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
      cnt_q  <= '0;
    end else begin
      data_q <= data_d;
      cnt_q  <= cnt_d;
    end
  end

  assign data_o = data_q;
  assign cnt_o  = cnt_q;
endmodule

// File: rtl/aes_input_loader.sv
// Assembles a 256-bit key and 128-bit blocks from 32-bit streams, then holds them
// steady with en_o high until the AES core reports done_i or the watchdog expires.
module aes_input_loader
  import aes_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 4095
) (
  input  logic                            clk_i,
  input  logic                            rst_n,
  input  logic [WORD_W-1:0]               key_word_i,
  input  logic                            key_valid_i,
  output logic                            key_ready_o,
  input  logic [WORD_W-1:0]               data_word_i,
  input  logic                            data_valid_i,
  output logic                            data_ready_o,
  output logic [BLK_WORDS*WORD_W-1:0]     plaintext_o,
  output logic [KEY_WORDS*WORD_W-1:0]     key_o,
  output logic                            en_o,
  input  logic                            done_i,
  output logic                            key_loaded_o,
  output logic [15:0]                     blocks_o,
  output logic                            err_o
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  state_e                       state_q, state_d;
  logic [TW-1:0]                timer_q, timer_d;
  logic [15:0]                  blocks_q, blocks_d;
  logic                         err_q, err_d;
  logic                         key_loaded_q, key_loaded_d;
  logic                         key_acc, data_acc, key_full, data_full;
  logic [$clog2(KEY_WORDS)-1:0] key_cnt;
  logic [$clog2(BLK_WORDS)-1:0] data_cnt;

  // Key words only start between blocks; a key word wins over a data word in the same cycle.
  assign key_ready_o  = (state_q == ST_FILL) && (data_cnt == '0);
  assign key_acc      = key_valid_i && key_ready_o;
  assign data_ready_o = (state_q == ST_FILL) && key_loaded_q && (key_cnt == '0) && !key_acc;
  assign data_acc     = data_valid_i && data_ready_o;

  aes_word_shifter #(.NWORDS(KEY_WORDS)) u_key (
    .clk_i   (clk_i),
    .rst_n   (rst_n),
    .shift_i (key_acc),
    .word_i  (key_word_i),
    .data_o  (key_o),
    .cnt_o   (key_cnt),
    .full_o  (key_full)
  );

  aes_word_shifter #(.NWORDS(BLK_WORDS)) u_data (
    .clk_i   (clk_i),
    .rst_n   (rst_n),
    .shift_i (data_acc),
    .word_i  (data_word_i),
    .data_o  (plaintext_o),
    .cnt_o   (data_cnt),
    .full_o  (data_full)
  );

  always_comb begin
    state_d      = state_q;
    timer_d      = timer_q;
    blocks_d     = blocks_q;
    err_d        = err_q;
    key_loaded_d = key_loaded_q;
    if (key_full)
      key_loaded_d = 1'b1;
    else if (key_acc && key_cnt == '0)
      key_loaded_d = 1'b0;
    case (state_q)
      ST_FILL: begin
        if (data_full) begin
          state_d = ST_RUN;
          timer_d = '0;
        end
      end
      ST_RUN: begin
        // Completion takes precedence over a timeout landing in the same cycle.
        if (done_i) begin
          state_d  = ST_FILL;
          blocks_d = blocks_q + 16'd1;
        end else if (timer_q == TW'(TIMEOUT_CYCLES - 1)) begin
          state_d = ST_FILL;
          err_d   = 1'b1;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      default: state_d = ST_FILL;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_FILL;
      timer_q      <= '0;
      blocks_q     <= '0;
      err_q        <= 1'b0;
      key_loaded_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      blocks_q     <= blocks_d;
      err_q        <= err_d;
      key_loaded_q <= key_loaded_d;
    end
  end

  assign en_o         = (state_q == ST_RUN);
  assign key_loaded_o = key_loaded_q;
  assign blocks_o     = blocks_q;
  assign err_o        = err_q;
endmodule

// File: tb/tb_aes_input_loader.sv
// Directed bench: table of per-cycle stimulus/expectations plus hand-written
// sequences for timeout, reset mid-run and block-counter wrap.
module tb_aes_input_loader;
  logic         clk_i = 1'b0;
  logic         rst_n = 1'b0;
  logic [31:0]  key_word_i = '0, data_word_i = '0;
  logic         key_valid_i = 1'b0, data_valid_i = 1'b0, done_i = 1'b0;
  logic         key_ready_o, data_ready_o, en_o, key_loaded_o, err_o;
  logic [127:0] plaintext_o;
  logic [255:0] key_o;
  logic [15:0]  blocks_o;

  int total = 0;
  int bad   = 0;

  aes_input_loader #(.TIMEOUT_CYCLES(16)) dut (
    .clk_i        (clk_i),
    .rst_n        (rst_n),
    .key_word_i   (key_word_i),
    .key_valid_i  (key_valid_i),
    .key_ready_o  (key_ready_o),
    .data_word_i  (data_word_i),
    .data_valid_i (data_valid_i),
    .data_ready_o (data_ready_o),
    .plaintext_o  (plaintext_o),
    .key_o        (key_o),
    .en_o         (en_o),
    .done_i       (done_i),
    .key_loaded_o (key_loaded_o),
    .blocks_o     (blocks_o),
    .err_o        (err_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        kv;
    logic [31:0] kw;
    logic        dv;
    logic [31:0] dw;
    logic        dn;
    logic        ekr, edr, een, ekl;
    logic [15:0] eblk;
  } vec_t;

  vec_t tbl[$];

  localparam logic [255:0] FIPS_KEY = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [255:0] TEST_KEY = {8{32'h74657374}};
  localparam logic [127:0] TEST_PT  = 128'h616c656e6b72757468616c656e6b7275;

  function automatic vec_t mk(logic kv, logic [31:0] kw, logic dv, logic [31:0] dw, logic dn,
                              logic ekr, logic edr, logic een, logic ekl, logic [15:0] eblk);
    vec_t r;
    r.kv = kv; r.kw = kw; r.dv = dv; r.dw = dw; r.dn = dn;
    r.ekr = ekr; r.edr = edr; r.een = een; r.ekl = ekl; r.eblk = eblk;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask

  // Drive one cycle's inputs in the low phase and let combinational outputs settle.
  task automatic cyc(input logic kv, input logic [31:0] kw, input logic dv,
                     input logic [31:0] dw, input logic dn);
    @(negedge clk_i);
    key_valid_i = kv; key_word_i = kw;
    data_valid_i = dv; data_word_i = dw; done_i = dn;
    #1;
  endtask

  task automatic run_tbl(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      cyc(tbl[i].kv, tbl[i].kw, tbl[i].dv, tbl[i].dw, tbl[i].dn);
      chk($sformatf("key_ready[%0d]", i),  256'(key_ready_o),  256'(tbl[i].ekr));
      chk($sformatf("data_ready[%0d]", i), 256'(data_ready_o), 256'(tbl[i].edr));
      chk($sformatf("en[%0d]", i),         256'(en_o),         256'(tbl[i].een));
      chk($sformatf("key_loaded[%0d]", i), 256'(key_loaded_o), 256'(tbl[i].ekl));
      chk($sformatf("blocks[%0d]", i),     256'(blocks_o),     256'(tbl[i].eblk));
    end
  endtask

  task automatic load_key(input logic [255:0] k);
    for (int i = 0; i < 8; i++) cyc(1'b1, k[255-32*i -: 32], 1'b0, 32'h0, 1'b0);
  endtask

  task automatic load_blk(input logic [127:0] p);
    for (int i = 0; i < 4; i++) cyc(1'b0, 32'h0, 1'b1, p[127-32*i -: 32], 1'b0);
  endtask

  initial begin
    logic [31:0] w;
    int n_high;

    // FIPS-197 key and block, one completed encryption.
    for (int i = 0; i < 8; i++) begin
      w = {8'(4*i), 8'(4*i+1), 8'(4*i+2), 8'(4*i+3)};
      tbl.push_back(mk(1, w, 0, 0, 0, 1, 0, 0, 0, 0));
    end
    for (int j = 0; j < 4; j++)
      tbl.push_back(mk(0, 0, 1, FIPS_PT[127-32*j -: 32], 0, j == 0, 1, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 1, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 1, 0, 1, 1));
    // Key and data offered together: key wins, data word is refused.
    tbl.push_back(mk(1, 32'h74657374, 1, 32'hdeadbeef, 0, 1, 0, 0, 1, 1));
    for (int i = 1; i < 8; i++)
      tbl.push_back(mk(1, 32'h74657374, 0, 0, 0, 1, 0, 0, 0, 1));
    for (int j = 0; j < 4; j++)
      tbl.push_back(mk(0, 0, 1, TEST_PT[127-32*j -: 32], 0, j == 0, 1, 0, 1, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 1));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 1, 1, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 1, 0, 1, 2));

    // Reset state.
    #2;
    chk("rst_en", 256'(en_o), 256'(0));
    chk("rst_key", key_o, 256'(0));
    chk("rst_pt", 256'(plaintext_o), 256'(0));
    chk("rst_kl", 256'(key_loaded_o), 256'(0));
    chk("rst_blocks", 256'(blocks_o), 256'(0));
    chk("rst_err", 256'(err_o), 256'(0));
    @(negedge clk_i);
    rst_n = 1'b1;

    run_tbl(0, 12);
    chk("fips_key", key_o, FIPS_KEY);
    chk("fips_pt", 256'(plaintext_o), 256'(FIPS_PT));
    run_tbl(13, 29);
    chk("test_key", key_o, TEST_KEY);
    chk("test_pt", 256'(plaintext_o), 256'(TEST_PT));
    chk("err_after_tbl", 256'(err_o), 256'(0));

    // done_i in FILL is ignored.
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0);
    chk("fill_done_blocks", 256'(blocks_o), 256'(2));
    chk("fill_done_en", 256'(en_o), 256'(0));

    // done_i on the last timer cycle counts as completion.
    load_blk(TEST_PT);
    for (int i = 0; i < 15; i++) cyc(0, 0, 0, 0, 0);
    chk("late_done_en", 256'(en_o), 256'(1));
    cyc(0, 0, 0, 0, 1);
    chk("late_done_en_last", 256'(en_o), 256'(1));
    cyc(0, 0, 0, 0, 0);
    chk("late_done_en_off", 256'(en_o), 256'(0));
    chk("late_done_err", 256'(err_o), 256'(0));
    chk("late_done_blocks", 256'(blocks_o), 256'(3));

    // Timeout with done_i held low: 16 RUN cycles, then err.
    load_blk(TEST_PT);
    n_high = 0;
    for (int i = 0; i < 40; i++) begin
      cyc(0, 0, 0, 0, 0);
      if (en_o) n_high++;
      else break;
    end
    chk("timeout_run_cycles", 256'(n_high), 256'(16));
    chk("timeout_err", 256'(err_o), 256'(1));
    chk("timeout_blocks", 256'(blocks_o), 256'(3));
    chk("timeout_pt_held", 256'(plaintext_o), 256'(TEST_PT));
    cyc(0, 0, 0, 0, 0);
    chk("err_sticky", 256'(err_o), 256'(1));

    // Asynchronous reset mid-RUN.
    load_blk(FIPS_PT);
    cyc(0, 0, 0, 0, 0);
    chk("pre_rst_en", 256'(en_o), 256'(1));
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_en", 256'(en_o), 256'(0));
    chk("mid_rst_kl", 256'(key_loaded_o), 256'(0));
    chk("mid_rst_key", key_o, 256'(0));
    chk("mid_rst_err", 256'(err_o), 256'(0));
    chk("mid_rst_blocks", 256'(blocks_o), 256'(0));
    @(negedge clk_i);
    rst_n = 1'b1;
    cyc(0, 0, 1, 32'h11111111, 0);
    chk("post_rst_dready0", 256'(data_ready_o), 256'(0));
    cyc(0, 0, 1, 32'h11111111, 0);
    chk("post_rst_dready1", 256'(data_ready_o), 256'(0));
    load_key(FIPS_KEY);
    cyc(0, 0, 1, 32'h11111111, 0);
    chk("reload_dready", 256'(data_ready_o), 256'(1));
    chk("reload_kl", 256'(key_loaded_o), 256'(1));
    cyc(0, 0, 0, 0, 0);

    // Block counter wraps from FFFF to 0000; first data word above left data count at 1.
    force dut.blocks_q = 16'hFFFF;
    #1 release dut.blocks_q;
    #1;
    chk("preload_blocks", 256'(blocks_o), 256'(16'hFFFF));
    for (int i = 1; i < 4; i++) cyc(0, 0, 1, FIPS_PT[127-32*i -: 32], 0);
    cyc(0, 0, 0, 0, 1);
    chk("wrap_en", 256'(en_o), 256'(1));
    cyc(0, 0, 0, 0, 0);
    chk("wrap_blocks", 256'(blocks_o), 256'(0));
    chk("wrap_pt", 256'(plaintext_o), 256'({32'h11111111, FIPS_PT[95:0]}));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/aes_input_loader.md
AES_INPUT_LOADER -- requirements
Module: aes_input_loader

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 4095: maximum cycles in RUN waiting for done_i before aborting.
REQ-002 SHALL have one clock; reset is asynchronous and active-low.
REQ-003 clk_i  input  1  clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 key_word_i  input  32  key word; first word of a key = bits 255:224.
REQ-006 key_valid_i  input  1  key word valid.
REQ-007 key_ready_o  output  1  key word accepted when key_valid_i and key_ready_o are both high.
REQ-008 data_word_i  input  32  plaintext word; first word of a block = bits 127:96.
REQ-009 data_valid_i  input  1  plaintext word valid.
REQ-010 data_ready_o  output  1  plaintext word accepted when data_valid_i and data_ready_o are both high.
REQ-011 plaintext_o  output  128  assembled block to the AES core plaintext_i.
REQ-012 key_o  output  256  assembled key to the AES core key_i.
REQ-013 en_o  output  1  drives the AES core en_i; high for the whole encryption.
REQ-014 done_i  input  1  AES core done_o.
REQ-015 key_loaded_o  output  1  a complete 8-word key is held.
REQ-016 blocks_o  output  16  count of completed blocks.
REQ-017 err_o  output  1  sticky timeout flag.

Function
REQ-018 SHALL implement FSM states FILL and RUN only.
REQ-019 FILL: key_ready_o = (data word count == 0).
REQ-020 FILL: data_ready_o = key_loaded_o AND (key word count == 0) AND NOT (key_valid_i AND key_ready_o); key has priority.
REQ-021 RUN: key_ready_o = 0 and data_ready_o = 0.
REQ-022 Each accepted word SHALL shift in from the LSB end: register <= {register[W-33:0], word}.
REQ-023 First accepted key word SHALL clear key_loaded_o on the next edge; the 8th SHALL set it and reset the key count to 0.
REQ-024 The 4th accepted data word SHALL move FILL->RUN; en_o SHALL be registered high on that same edge, giving 1 cycle latency from the 4th handshake.
REQ-025 plaintext_o and key_o SHALL not change while en_o is high.
REQ-026 RUN: done_i sampled high SHALL move RUN->FILL; en_o low next edge; blocks_o +1 with modulo 2^16 wrap.
REQ-027 RUN: the timer SHALL start at 0 on entry and increment each cycle; at TIMEOUT_CYCLES-1 without done_i: RUN->FILL, en_o low, err_o set, blocks_o unchanged.
REQ-028 done_i in the same cycle as timeout SHALL count as completion (no error).
REQ-029 done_i while in FILL SHALL be ignored.
REQ-030 err_o SHALL stay set until reset.

Reset
REQ-031 On rst_n low, all outputs SHALL be 0 asynchronously: plaintext_o, key_o, en_o, key_loaded_o, blocks_o, err_o; FSM = FILL; all counts and the timer = 0.
REQ-032 Reset mid-RUN SHALL drop en_o immediately and discard the key (key_loaded_o = 0).

Structure
REQ-033 Package aes_pkg SHALL hold the state enum, KEY_WORDS=8, BLK_WORDS=4 and WORD_W=32.
REQ-034 Sub-module aes_word_shifter (parameter NWORDS; shift register plus word count plus full pulse) SHALL be instantiated twice: once for the key and once for the data.

Verification
REQ-035 Key 000102..1f (8 words), then data 00112233,44556677,8899aabb,ccddeeff -> key_o/plaintext_o match FIPS-197; en_o high 1 cycle after the 4th handshake; with the AES core attached, ciphertext = 8ea2b7ca516745bfeafc49904b496089.
REQ-036 Key "testtest..." (8 x 74657374), data 616c656e,6b727574,68616c65,6e6b7275 -> ciphertext 4419ce8172f99fa38dc6119260edb3f8; blocks_o = 1.
REQ-037 key_valid_i and data_valid_i both high with counts 0 -> only the key word is accepted; data_ready_o = 0 that cycle.
REQ-038 TIMEOUT_CYCLES=16, done_i held 0 -> en_o falls after 16 RUN cycles; err_o = 1; blocks_o unchanged.
REQ-039 rst_n pulsed low mid-RUN -> en_o = 0 immediately; key_loaded_o = 0; data_ready_o = 0 until a new key is loaded.
REQ-040 Preload blocks_o to FFFF via 65535 blocks or force, then complete one block -> blocks_o = 0000.
